// File: rtl/mul_div_unit.sv
// Iterative 32-bit MIPS multiply/divide unit holding HI/LO: shift-add multiply, restoring divide.
// Signed MULT/DIV (op[0]) is compiled in only when MULDIV_SIGNED_EN is defined.
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(ITER);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic             is_div_q;
    logic             neg_res_q;
    logic             neg_rem_q;
    logic             dbz_q;
    logic [WIDTH-1:0] a_raw_q;
    logic [WIDTH-1:0] opnd_q;    // multiplicand or divisor magnitude
    logic [WIDTH-1:0] acc_hi_q;  // upper partial product or remainder
    logic [WIDTH-1:0] acc_lo_q;  // multiplier/lower product or quotient
    logic             busy_q;
    logic             done_q;
    logic             dbz_out_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic             signed_op;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    logic [WIDTH:0]   add_x;
    logic [WIDTH:0]   add_y;
    logic             add_cin;
    logic [WIDTH+1:0] add_full;
    logic [WIDTH-1:0] acc_hi_d;
    logic [WIDTH-1:0] acc_lo_d;

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

`ifdef MULDIV_SIGNED_EN
    assign signed_op = op[0];
`else
    logic unused_op0;
    assign unused_op0 = op[0];
    assign signed_op  = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        a_neg = signed_op & a[WIDTH-1];
        b_neg = signed_op & b[WIDTH-1];
        a_mag = a_neg ? (~a + 1'b1) : a;
        b_mag = b_neg ? (~b + 1'b1) : b;
    end

    // One shared 33-bit adder: subtract for divide (carry out = no borrow), add for multiply.
    always_comb begin
        add_x   = '0;
        add_y   = '0;
        add_cin = 1'b0;
        if (is_div_q) begin
            add_x   = {acc_hi_q, acc_lo_q[WIDTH-1]};
            add_y   = ~{1'b0, opnd_q};
            add_cin = 1'b1;
        end else begin
            add_x = {1'b0, acc_hi_q};
            add_y = acc_lo_q[0] ? {1'b0, opnd_q} : '0;
        end
        add_full = {1'b0, add_x} + {1'b0, add_y} + {{(WIDTH+1){1'b0}}, add_cin};
    end

    always_comb begin
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        if (is_div_q) begin
            if (add_full[WIDTH+1]) begin
                acc_hi_d = add_full[WIDTH-1:0];
                acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_hi_d = add_x[WIDTH-1:0];
                acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_hi_d = add_full[WIDTH:1];
            acc_lo_d = {add_full[0], acc_lo_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod     = {acc_hi_q, acc_lo_q};
        prod_fix = neg_res_q ? (~prod + 1'b1) : prod;
        quot_fix = neg_res_q ? (~acc_lo_q + 1'b1) : acc_lo_q;
        rem_fix  = neg_rem_q ? (~acc_hi_q + 1'b1) : acc_hi_q;
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
            a_raw_q   <= '0;
            opnd_q    <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_out_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            done_q    <= 1'b0;
            dbz_out_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        is_div_q  <= op[1];
                        neg_res_q <= a_neg ^ b_neg;
                        neg_rem_q <= op[1] & a_neg;
                        dbz_q     <= op[1] & (b == '0);
                        a_raw_q   <= a;
                        cnt_q     <= '0;
                        acc_hi_q  <= '0;
                        if (op[1]) begin
                            opnd_q   <= b_mag;
                            acc_lo_q <= a_mag;
                        end else begin
                            opnd_q   <= a_mag;
                            acc_lo_q <= b_mag;
                        end
                        busy_q  <= 1'b1;
                        state_q <= S_CALC;
                    end
                end
                S_CALC: begin
                    acc_hi_q <= acc_hi_d;
                    acc_lo_q <= acc_lo_d;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CW'(ITER - 1)) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    // Divide by zero reports the raw dividend and all-ones quotient, unsigned.
                    if (dbz_q) begin
                        hi_q <= a_raw_q;
                        lo_q <= '1;
                    end else if (is_div_q) begin
                        hi_q <= rem_fix;
                        lo_q <= quot_fix;
                    end else begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end
                    dbz_out_q <= dbz_q;
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_out_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vectors, handshake/reset, randomized ops vs a model.
module tb_mul_div_unit;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

`ifdef MULDIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op    = '0;
    logic [31:0] a     = '0;
    logic [31:0] b     = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    int n_pass  = 0;
    int n_total = 0;

    mul_div_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference: plain 64-bit integer arithmetic following the MIPS HI/LO rules.
    function automatic void ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                   output logic [31:0] e_hi, output logic [31:0] e_lo,
                                   output logic e_dbz);
        bit          sgn;
        longint      sx, sy, q, r;
        logic [63:0] p;
        sgn   = SIGNED_EN && o[0];
        e_dbz = 1'b0;
        sx    = sgn ? longint'($signed(x)) : longint'({32'b0, x});
        sy    = sgn ? longint'($signed(y)) : longint'({32'b0, y});
        if (!o[1]) begin
            p    = 64'(sx * sy);
            e_hi = p[63:32];
            e_lo = p[31:0];
        end else if (y == 32'd0) begin
            e_hi  = x;
            e_lo  = 32'hFFFF_FFFF;
            e_dbz = 1'b1;
        end else begin
            q    = sx / sy;
            r    = sx % sy;
            e_lo = q[31:0];
            e_hi = r[31:0];
        end
    endfunction

    // Called #1 after a rising edge; start is seen on the next edge (E0).
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 2'($urandom);
        a     = $urandom;
        b     = $urandom;
        check("busy_after_start", {63'b0, busy}, 64'd1);
        check("done_one_cycle", {63'b0, done}, 64'd0);
    endtask

    task automatic wait_done(input int n0, output int n);
        bit seen;
        bit busy_ok;
        seen    = 1'b0;
        busy_ok = 1'b1;
        n       = n0;
        while (!seen && n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (done) seen = 1'b1;
            else if (!busy) busy_ok = 1'b0;
        end
        check("done_seen", {63'b0, seen}, 64'd1);
        check("busy_held", {63'b0, busy_ok}, 64'd1);
        check("busy_low_at_done", {63'b0, busy}, 64'd0);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] e_hi, e_lo;
        logic        e_dbz;
        int          n;
        ref_op(o, x, y, e_hi, e_lo, e_dbz);
        issue(o, x, y);
        wait_done(0, n);
        check("latency", 64'(n), 64'd33);
        check("hi", {32'b0, hi}, {32'b0, e_hi});
        check("lo", {32'b0, lo}, {32'b0, e_lo});
        check("div_by_zero", {63'b0, div_by_zero}, {63'b0, e_dbz});
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 255));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int  n;
        bit  saw_done;

        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_hi", {32'b0, hi}, 64'd0);
        check("rst_lo", {32'b0, lo}, 64'd0);
        check("rst_dbz", {63'b0, div_by_zero}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("tp_multu_hi", {32'b0, hi}, 64'hFFFF_FFFE);
        check("tp_multu_lo", {32'b0, lo}, 64'h0000_0001);

        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7);
`ifdef MULDIV_SIGNED_EN
        check("tp_mult_hi", {32'b0, hi}, 64'hFFFF_FFFF);
`else
        check("tp_mult_hi", {32'b0, hi}, 64'h0000_0006);
`endif
        check("tp_mult_lo", {32'b0, lo}, 64'hFFFF_FFEB);

        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
`ifdef MULDIV_SIGNED_EN
        check("tp_div_lo", {32'b0, lo}, 64'hFFFF_FFFD);
        check("tp_div_hi", {32'b0, hi}, 64'hFFFF_FFFF);
`endif

        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
`ifdef MULDIV_SIGNED_EN
        check("tp_ovf_lo", {32'b0, lo}, 64'h8000_0000);
        check("tp_ovf_hi", {32'b0, hi}, 64'd0);
        check("tp_ovf_dbz", {63'b0, div_by_zero}, 64'd0);
`endif

        run_op(OP_DIVU, 32'd100, 32'd0);
        check("tp_dbz_hi", {32'b0, hi}, 64'h0000_0064);
        check("tp_dbz_lo", {32'b0, lo}, 64'hFFFF_FFFF);
        check("tp_dbz_flag", {63'b0, div_by_zero}, 64'd1);

        run_op(OP_DIV, 32'h8000_0005, 32'd0);
        check("tp_sdbz_hi", {32'b0, hi}, 64'h8000_0005);

        // A second start while busy must be dropped, not queued.
        issue(OP_MULTU, 32'd5, 32'd6);
        n = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            n++;
        end
        op    = OP_DIVU;
        a     = 32'd9;
        b     = 32'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        n++;
        start = 1'b0;
        wait_done(n, n);
        check("ign_latency", 64'(n), 64'd33);
        check("ign_hi", {32'b0, hi}, 64'd0);
        check("ign_lo", {32'b0, lo}, 64'd30);
        repeat (3) @(posedge clk);
        #1;
        check("ign_no_queue", {62'b0, busy, done}, 64'd0);

        issue(OP_MULTU, 32'd1234, 32'd5678);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {63'b0, busy}, 64'd0);
        check("abort_hi", {32'b0, hi}, 64'd0);
        check("abort_lo", {32'b0, lo}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        check("abort_no_done", {63'b0, saw_done}, 64'd0);

        // Back-to-back: each op starts in the cycle its predecessor shows done.
        for (int i = 0; i < 60; i++) begin
            run_op(2'($urandom), pick_operand(), pick_operand());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
